tlb_asid_lut: RTL and testbench

Second-generation set-associative Sv32 translation lookaside buffer, built from distributed LUT RAM and sitting between a fetch/load-store unit and the shared page-table walker. It is parametrised in ways, sets and ASID width. It adds the following over the first-generation TLB:
- ASID and global tagging.
- Three SFENCE.VMA flush modes: all, by ASID, by address.
- Invalid-way-first replacement.
- A self-clearing sweep after reset.

---
 rtl/tlb_asid_lut.sv | 248 ++++++++++++++++++++++++
 tb/tb_tlb_asid_lut.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_asid_lut.sv
`default_nettype none
// ============================================================================
// Module   : tlb_asid_lut
// Brief    : Set-associative Sv32 TLB in distributed LUT RAM with ASID/global
//            tagging, SFENCE.VMA flush modes (all / by ASID / by address),
//            invalid-way-first replacement and a clearing sweep after reset.
// Revision : 2.0 - ASID tagging, flush modes, reset sweep
// ============================================================================
module tlb_asid_lut #(
    parameter int WAYS   = 2,
    parameter int DEPTH  = 32,
    parameter int ASID_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tlb_on,
    input  logic [ASID_W-1:0] asid,
    input  logic [31:0]       vaddr,
    input  logic              new_request,
    input  logic              execute,
    input  logic              rnw,
    output logic              complete,
    output logic [31:0]       paddr,
    input  logic              flush,
    input  logic [1:0]        flush_mode,
    input  logic [ASID_W-1:0] flush_asid,
    input  logic [31:0]       flush_vaddr,
    output logic              flush_complete,
    output logic              mmu_request,
    output logic [31:0]       mmu_vaddr,
    output logic              mmu_execute,
    output logic              mmu_rnw,
    input  logic              mmu_write_entry,
    input  logic [19:0]       mmu_ppn,
    input  logic              mmu_global
);

    localparam int IDX_W   = $clog2(DEPTH);
    localparam int TAG_W   = 20 - IDX_W;
    localparam int RR_W    = (WAYS > 1) ? $clog2(WAYS) : 1;
    // Entry layout, LSB first: ppn, tag, asid, global, valid
    localparam int TAG_LO  = 20;
    localparam int ASID_LO = TAG_LO + TAG_W;
    localparam int G_B     = ASID_LO + ASID_W;
    localparam int V_B     = G_B + 1;
    localparam int E_W     = V_B + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SWEEP  = 2'd1,
        ST_DONE   = 2'd2,
        ST_RSWEEP = 2'd3
    } state_t;

    state_t              r_state;
    logic [IDX_W-1:0]    r_idx;
    logic [RR_W-1:0]     r_rr;
    logic                r_mmu_request;
    logic                r_flush_complete;
    logic                r_asid_mode;

    logic [IDX_W-1:0]    w_lk_idx;
    logic [TAG_W-1:0]    w_lk_tag;
    logic [IDX_W-1:0]    w_fl_idx;
    logic [TAG_W-1:0]    w_fl_tag;
    logic                w_busy;

    logic [WAYS-1:0]     w_hit;
    logic [WAYS-1:0]     w_lk_valid;
    logic [19:0]         w_lk_ppn [WAYS];
    logic [WAYS-1:0]     w_fl_valid;
    logic [WAYS-1:0]     w_fl_global;
    logic [WAYS-1:0]     w_fl_asid_eq;
    logic [WAYS-1:0]     w_fl_tag_eq;

    logic                w_any_hit;
    logic [19:0]         w_hit_ppn;
    logic                w_has_inv;
    logic [RR_W-1:0]     w_inv_way;
    logic [RR_W-1:0]     w_fill_way;
    logic                w_fill_go;
    logic                w_flush_go;

    logic [WAYS-1:0]     w_we;
    logic [IDX_W-1:0]    w_waddr;
    logic [E_W-1:0]      w_wdata;

    logic                w_unused_flush_lsbs;

    assign w_lk_idx   = vaddr[IDX_W+11:12];
    assign w_lk_tag   = vaddr[31:32-TAG_W];
    assign w_fl_tag   = flush_vaddr[31:32-TAG_W];
    // The second read port follows the flush address in IDLE, the sweep index otherwise
    assign w_fl_idx   = (r_state == ST_IDLE) ? flush_vaddr[IDX_W+11:12] : r_idx;
    assign w_busy     = (r_state != ST_IDLE);
    assign w_flush_go = (r_state == ST_IDLE) && flush;
    assign w_fill_go  = (r_state == ST_IDLE) && mmu_write_entry && !flush;

    assign w_unused_flush_lsbs = ^flush_vaddr[11:0];

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        logic [E_W-1:0] r_mem [DEPTH];
        logic [E_W-1:0] w_ent;

        assign w_ent           = r_mem[w_lk_idx];
        assign w_lk_valid[g]   = w_ent[V_B];
        assign w_lk_ppn[g]     = w_ent[19:0];
        assign w_hit[g]        = w_ent[V_B] && (w_ent[ASID_LO-1:TAG_LO] == w_lk_tag) &&
                                 (w_ent[G_B] || (w_ent[G_B-1:ASID_LO] == asid));

        assign w_fl_valid[g]   = r_mem[w_fl_idx][V_B];
        assign w_fl_global[g]  = r_mem[w_fl_idx][G_B];
        assign w_fl_asid_eq[g] = (r_mem[w_fl_idx][G_B-1:ASID_LO] == flush_asid);
        assign w_fl_tag_eq[g]  = (r_mem[w_fl_idx][ASID_LO-1:TAG_LO] == w_fl_tag);

        // Single write port per way, shared by fill, flush and sweep
        always_ff @(posedge clk) begin
            if (w_we[g]) begin
                r_mem[w_waddr] <= w_wdata;
            end
        end
    end

    // Hit select and fill-way choice; descending scan so the lowest way wins
    always_comb begin
        w_any_hit = 1'b0;
        w_hit_ppn = '0;
        w_has_inv = 1'b0;
        w_inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (w_hit[w]) begin
                w_any_hit = 1'b1;
                w_hit_ppn = w_lk_ppn[w];
            end
            if (!w_lk_valid[w]) begin
                w_has_inv = 1'b1;
                w_inv_way = RR_W'(w);
            end
        end
        w_fill_way = w_has_inv ? w_inv_way : r_rr;
    end

    // Write-port steering: address flush or fill in IDLE, per-set clears while sweeping
    always_comb begin
        w_we    = '0;
        w_waddr = w_lk_idx;
        w_wdata = '0;
        case (r_state)
            ST_IDLE: begin
                if (flush) begin
                    if (flush_mode == 2'd2) begin
                        w_waddr = w_fl_idx;
                        for (int w = 0; w < WAYS; w++) begin
                            w_we[w] = w_fl_valid[w] && w_fl_tag_eq[w] &&
                                      (!w_fl_global[w] || w_fl_asid_eq[w]);
                        end
                    end
                end else if (mmu_write_entry) begin
                    w_wdata = {1'b1, mmu_global, asid, w_lk_tag, mmu_ppn};
                    for (int w = 0; w < WAYS; w++) begin
                        w_we[w] = (w_fill_way == RR_W'(w));
                    end
                end
            end
            ST_SWEEP: begin
                w_waddr = r_idx;
                for (int w = 0; w < WAYS; w++) begin
                    w_we[w] = r_asid_mode ?
                              (w_fl_valid[w] && !w_fl_global[w] && w_fl_asid_eq[w]) : 1'b1;
                end
            end
            ST_RSWEEP: begin
                w_waddr = r_idx;
                w_we    = '1;
            end
            default: ;
        endcase
    end

    // Control FSM: flush/sweep sequencing, miss request, round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= ST_RSWEEP;
            r_idx            <= '0;
            r_rr             <= '0;
            r_mmu_request    <= 1'b0;
            r_flush_complete <= 1'b0;
            r_asid_mode      <= 1'b0;
        end else begin
            r_flush_complete <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (flush) begin
                        if (flush_mode == 2'd2) begin
                            r_state          <= ST_DONE;
                            r_flush_complete <= 1'b1;
                        end else begin
                            r_state     <= ST_SWEEP;
                            r_idx       <= '0;
                            r_asid_mode <= (flush_mode == 2'd1);
                        end
                    end
                end
                ST_SWEEP: begin
                    if (r_idx == IDX_W'(DEPTH - 1)) begin
                        r_state          <= ST_DONE;
                        r_flush_complete <= 1'b1;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                ST_RSWEEP: begin
                    if (r_idx == IDX_W'(DEPTH - 1)) begin
                        r_state <= ST_IDLE;
                        r_idx   <= '0;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
            endcase

            // A flush cancels any outstanding walk; the fill strobe retires it
            if (w_flush_go || mmu_write_entry) begin
                r_mmu_request <= 1'b0;
            end else if (new_request && tlb_on && !w_any_hit && !w_busy) begin
                r_mmu_request <= 1'b1;
            end

            // Pointer only moves when it actually chose the victim
            if (w_fill_go && !w_has_inv) begin
                r_rr <= (r_rr == RR_W'(WAYS - 1)) ? '0 : r_rr + 1'b1;
            end
        end
    end

    assign complete       = !w_busy && (!tlb_on || w_any_hit);
    assign paddr          = {(tlb_on && w_any_hit) ? w_hit_ppn : vaddr[31:12], vaddr[11:0]};
    assign flush_complete = r_flush_complete;
    assign mmu_request    = r_mmu_request;
    assign mmu_vaddr      = vaddr;
    assign mmu_execute    = execute;
    assign mmu_rnw        = rnw;

endmodule
`default_nettype wire

// File: tb/tb_tlb_asid_lut.sv
`default_nettype none
// ============================================================================
// Module   : tb_tlb_asid_lut
// Brief    : Directed self-checking bench for tlb_asid_lut (WAYS=2, DEPTH=32).
// Revision : 2.0
// ============================================================================
module tb_tlb_asid_lut;

    localparam int ASID_W = 9;

    logic              clk;
    logic              rst;
    logic              tlb_on;
    logic [ASID_W-1:0] asid;
    logic [31:0]       vaddr;
    logic              new_request;
    logic              execute;
    logic              rnw;
    logic              complete;
    logic [31:0]       paddr;
    logic              flush;
    logic [1:0]        flush_mode;
    logic [ASID_W-1:0] flush_asid;
    logic [31:0]       flush_vaddr;
    logic              flush_complete;
    logic              mmu_request;
    logic [31:0]       mmu_vaddr;
    logic              mmu_execute;
    logic              mmu_rnw;
    logic              mmu_write_entry;
    logic [19:0]       mmu_ppn;
    logic              mmu_global;

    int n_vec;
    int n_err;

    tlb_asid_lut #(.WAYS(2), .DEPTH(32), .ASID_W(ASID_W)) dut (
        .clk(clk), .rst(rst), .tlb_on(tlb_on), .asid(asid), .vaddr(vaddr),
        .new_request(new_request), .execute(execute), .rnw(rnw),
        .complete(complete), .paddr(paddr), .flush(flush), .flush_mode(flush_mode),
        .flush_asid(flush_asid), .flush_vaddr(flush_vaddr), .flush_complete(flush_complete),
        .mmu_request(mmu_request), .mmu_vaddr(mmu_vaddr), .mmu_execute(mmu_execute),
        .mmu_rnw(mmu_rnw), .mmu_write_entry(mmu_write_entry), .mmu_ppn(mmu_ppn),
        .mmu_global(mmu_global)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_fill(input logic [31:0] va, input logic [ASID_W-1:0] a,
                           input logic [19:0] ppn, input logic g);
        vaddr = va; asid = a; mmu_ppn = ppn; mmu_global = g;
        mmu_write_entry = 1'b1;
        cyc();
        mmu_write_entry = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; tlb_on = 1'b0; asid = '0; vaddr = 32'h0040_0ABC; new_request = 1'b0;
        execute = 1'b0; rnw = 1'b1; flush = 1'b0; flush_mode = 2'd0; flush_asid = '0;
        flush_vaddr = '0; mmu_write_entry = 1'b0; mmu_ppn = '0; mmu_global = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        settle();
        n_vec++; if (mmu_request !== 1'b0) begin n_err++; $display("FAIL reset_mmu_request: got %b want 0", mmu_request); end
        n_vec++; if (flush_complete !== 1'b0) begin n_err++; $display("FAIL reset_flush_complete: got %b want 0", flush_complete); end
        for (int i = 0; i < 32; i++) begin
            n_vec++; if (complete !== 1'b0) begin n_err++; $display("FAIL reset_sweep_busy[%0d]: complete got %b want 0", i, complete); end
            cyc(); settle();
        end
        n_vec++; if (complete !== 1'b1) begin n_err++; $display("FAIL reset_sweep_end: complete got %b want 1", complete); end
        n_vec++; if (paddr !== 32'h0040_0ABC) begin n_err++; $display("FAIL bypass_paddr: got %h want 00400abc", paddr); end
    endtask

    task automatic test_miss_fill();
        tlb_on = 1'b1; asid = 9'd1; vaddr = 32'h0040_0ABC; new_request = 1'b1;
        execute = 1'b1; rnw = 1'b0;
        settle();
        n_vec++; if (complete !== 1'b0) begin n_err++; $display("FAIL first_lookup_miss: complete got %b want 0", complete); end
        n_vec++; if (paddr !== 32'h0040_0ABC) begin n_err++; $display("FAIL miss_paddr: got %h want 00400abc", paddr); end
        n_vec++; if (mmu_request !== 1'b0) begin n_err++; $display("FAIL req_not_early: got %b want 0", mmu_request); end
        n_vec++; if ({mmu_vaddr, mmu_execute, mmu_rnw} !== {32'h0040_0ABC, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL passthrough: got %h %b %b want 00400abc 1 0", mmu_vaddr, mmu_execute, mmu_rnw); end
        cyc();
        new_request = 1'b0;
        settle();
        n_vec++; if (mmu_request !== 1'b1) begin n_err++; $display("FAIL req_rise: got %b want 1", mmu_request); end
        mmu_write_entry = 1'b1; mmu_ppn = 20'h12345; mmu_global = 1'b0;
        settle();
        n_vec++; if (mmu_request !== 1'b1) begin n_err++; $display("FAIL req_hold: got %b want 1", mmu_request); end
        cyc();
        mmu_write_entry = 1'b0;
        settle();
        n_vec++; if (mmu_request !== 1'b0) begin n_err++; $display("FAIL req_clear: got %b want 0", mmu_request); end
        n_vec++; if (complete !== 1'b1) begin n_err++; $display("FAIL fill_hit: complete got %b want 1", complete); end
        n_vec++; if (paddr !== 32'h1234_5ABC) begin n_err++; $display("FAIL fill_paddr: got %h want 12345abc", paddr); end
        new_request = 1'b1;
        cyc();
        new_request = 1'b0;
        settle();
        n_vec++; if (mmu_request !== 1'b0) begin n_err++; $display("FAIL hit_no_req: got %b want 0", mmu_request); end
        tlb_on = 1'b0;
        settle();
        n_vec++; if (paddr !== 32'h0040_0ABC || complete !== 1'b1) begin
            n_err++; $display("FAIL off_bypass: paddr %h complete %b want 00400abc 1", paddr, complete); end
        tlb_on = 1'b1;
    endtask

    task automatic test_asid();
        do_fill(32'h0080_1000, 9'd3, 20'h0AAAA, 1'b0);
        asid = 9'd4; settle();
        n_vec++; if (complete !== 1'b0 || paddr !== 32'h0080_1000) begin
            n_err++; $display("FAIL asid_other_miss: complete %b paddr %h want 0 00801000", complete, paddr); end
        asid = 9'd3; settle();
        n_vec++; if (complete !== 1'b1 || paddr !== 32'h0AAA_A000) begin
            n_err++; $display("FAIL asid_own_hit: complete %b paddr %h want 1 0aaaa000", complete, paddr); end
        do_fill(32'h00C0_2000, 9'd3, 20'h0BBBB, 1'b1);
        asid = 9'd4; settle();
        n_vec++; if (complete !== 1'b1 || paddr !== 32'h0BBB_B000) begin
            n_err++; $display("FAIL global_hit: complete %b paddr %h want 1 0bbbb000", complete, paddr); end
        do_fill(32'h0100_3000, 9'd7, 20'h0CCCC, 1'b0);
    endtask

    task automatic test_replacement();
        do_fill(32'h0002_5000, 9'd1, 20'h0A001, 1'b0);
        do_fill(32'h0004_5000, 9'd1, 20'h0A002, 1'b0);
        do_fill(32'h0006_5000, 9'd1, 20'h0A003, 1'b0);
        vaddr = 32'h0002_5000; settle();
        n_vec++; if (complete !== 1'b0) begin n_err++; $display("FAIL repl_first_evicted: complete got %b want 0", complete); end
        vaddr = 32'h0004_5000; settle();
        n_vec++; if (complete !== 1'b1 || paddr !== 32'h0A00_2000) begin
            n_err++; $display("FAIL repl_second_kept: complete %b paddr %h want 1 0a002000", complete, paddr); end
        do_fill(32'h0008_5000, 9'd1, 20'h0A004, 1'b0);
        vaddr = 32'h0004_5000; settle();
        n_vec++; if (complete !== 1'b0) begin n_err++; $display("FAIL repl_ptr_advance: complete got %b want 0", complete); end
        vaddr = 32'h0006_5000; settle();
        n_vec++; if (complete !== 1'b1 || paddr !== 32'h0A00_3000) begin
            n_err++; $display("FAIL repl_third_kept: complete %b paddr %h want 1 0a003000", complete, paddr); end
        vaddr = 32'h0008_5000; settle();
        n_vec++; if (complete !== 1'b1 || paddr !== 32'h0A00_4000) begin
            n_err++; $display("FAIL repl_fourth_hit: complete %b paddr %h want 1 0a004000", complete, paddr); end
    endtask

    task automatic test_asid_flush();
        int  k;
        logic seen;
        flush_mode = 2'd1; flush_asid = 9'd3; flush = 1'b1;
        k = 0; seen = 1'b0;
        settle();
        n_vec++; if (flush_complete !== 1'b0) begin n_err++; $display("FAIL aflush_early: got %b want 0", flush_complete); end
        while (!seen && k < 40) begin
            cyc(); k++; settle();
            if (flush_complete === 1'b1) begin
                seen = 1'b1; flush = 1'b0;
            end else if (k == 5) begin
                vaddr = 32'h00C0_2000; asid = 9'd4; settle();
                n_vec++; if (complete !== 1'b0) begin n_err++; $display("FAIL busy_masks_hit: complete got %b want 0", complete); end
            end
        end
        flush = 1'b0;
        n_vec++; if (!seen || k != 33) begin n_err++; $display("FAIL aflush_latency: seen %b at %0d want 1 at 33", seen, k); end
        cyc(); settle();
        n_vec++; if (flush_complete !== 1'b0) begin n_err++; $display("FAIL aflush_pulse_width: got %b want 0", flush_complete); end
        vaddr = 32'h0080_1000; asid = 9'd3; settle();
        n_vec++; if (complete !== 1'b0) begin n_err++; $display("FAIL aflush_cleared: complete got %b want 0", complete); end
        vaddr = 32'h00C0_2000; asid = 9'd4; settle();
        n_vec++; if (complete !== 1'b1 || paddr !== 32'h0BBB_B000) begin
            n_err++; $display("FAIL aflush_global_kept: complete %b paddr %h want 1 0bbbb000", complete, paddr); end
        vaddr = 32'h0100_3000; asid = 9'd7; settle();
        n_vec++; if (complete !== 1'b1 || paddr !== 32'h0CCC_C000) begin
            n_err++; $display("FAIL aflush_other_asid_kept: complete %b paddr %h want 1 0cccc000", complete, paddr); end
    endtask

    task automatic test_addr_flush();
        flush_mode = 2'd2; flush_vaddr = 32'h0006_5000; flush_asid = 9'd0; flush = 1'b1;
        settle();
        n_vec++; if (flush_complete !== 1'b0) begin n_err++; $display("FAIL vflush_early: got %b want 0", flush_complete); end
        cyc(); settle();
        n_vec++; if (flush_complete !== 1'b1) begin n_err++; $display("FAIL vflush_latency: got %b want 1", flush_complete); end
        flush = 1'b0;
        cyc(); settle();
        n_vec++; if (flush_complete !== 1'b0) begin n_err++; $display("FAIL vflush_pulse_width: got %b want 0", flush_complete); end
        vaddr = 32'h0006_5000; asid = 9'd1; settle();
        n_vec++; if (complete !== 1'b0) begin n_err++; $display("FAIL vflush_cleared: complete got %b want 0", complete); end
        vaddr = 32'h0008_5000; settle();
        n_vec++; if (complete !== 1'b1 || paddr !== 32'h0A00_4000) begin
            n_err++; $display("FAIL vflush_neighbour_kept: complete %b paddr %h want 1 0a004000", complete, paddr); end
    endtask

    task automatic test_flush_during_miss();
        int  k;
        logic seen;
        vaddr = 32'h0140_4000; asid = 9'd1; new_request = 1'b1;
        settle();
        n_vec++; if (complete !== 1'b0) begin n_err++; $display("FAIL fm_miss: complete got %b want 0", complete); end
        cyc();
        new_request = 1'b0;
        settle();
        n_vec++; if (mmu_request !== 1'b1) begin n_err++; $display("FAIL fm_req: got %b want 1", mmu_request); end
        flush_mode = 2'd0; flush = 1'b1;
        k = 0; seen = 1'b0;
        while (!seen && k < 40) begin
            cyc(); k++;
            mmu_write_entry = (k == 10); mmu_ppn = 20'h0DDDD; mmu_global = 1'b0;
            settle();
            if (k == 1) begin
                n_vec++; if (mmu_request !== 1'b0) begin n_err++; $display("FAIL fm_req_drop: got %b want 0", mmu_request); end
            end
            if (flush_complete === 1'b1) begin
                seen = 1'b1; flush = 1'b0;
            end
        end
        flush = 1'b0; mmu_write_entry = 1'b0;
        n_vec++; if (!seen || k != 33) begin n_err++; $display("FAIL fflush_latency: seen %b at %0d want 1 at 33", seen, k); end
        cyc(); settle();
        n_vec++; if (complete !== 1'b0 || paddr !== 32'h0140_4000) begin
            n_err++; $display("FAIL fm_fill_dropped: complete %b paddr %h want 0 01404000", complete, paddr); end
        vaddr = 32'h0100_3000; asid = 9'd7; settle();
        n_vec++; if (complete !== 1'b0) begin n_err++; $display("FAIL fflush_all_cleared: complete got %b want 0", complete); end
    endtask

    task automatic test_flush_beats_fill();
        vaddr = 32'h0180_6000; asid = 9'd1; mmu_ppn = 20'h0EEEE; mmu_global = 1'b0;
        mmu_write_entry = 1'b1;
        flush_mode = 2'd2; flush_vaddr = 32'h0000_0000; flush = 1'b1;
        cyc();
        mmu_write_entry = 1'b0;
        settle();
        n_vec++; if (flush_complete !== 1'b1) begin n_err++; $display("FAIL ff_flush_done: got %b want 1", flush_complete); end
        flush = 1'b0;
        cyc(); settle();
        n_vec++; if (complete !== 1'b0) begin n_err++; $display("FAIL ff_fill_dropped: complete got %b want 0", complete); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_miss_fill();
        test_asid();
        test_replacement();
        test_asid_flush();
        test_addr_flush();
        test_flush_during_miss();
        test_flush_beats_fill();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
